tc_timer: RTL and testbench

Memory-mapped programmable timer/counter on the system bridge that drives one hardware-interrupt line into the coprocessor-0 `HWInt` vector (bit 2). The CPU programs it with store/load word accesses to three 32-bit registers. The counter runs down from a preset value and raises an interrupt request on expiry, either once or with automatic reload.

---
 rtl/tc_pkg.sv | 26 ++
 rtl/tc_prescaler.sv | 26 ++
 rtl/tc_timer.sv | 152 +++++++++++++++
 tb/tb_tc_timer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the tc_timer register block: FSM states, register
// word addresses, MODE encodings and CTRL bit positions.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PRE_LO  = 4;
  localparam int CTRL_PRE_HI  = 11;

endpackage

// File: rtl/tc_prescaler.sv
// Prescaler for tc_timer: 8-bit down-counter that ticks once every PRE+1
// cycles while running; restart reloads it so the first tick is PRE+1 away.
module tc_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       run,
  input  logic [7:0] pre,
  output logic       tick
);

  logic [7:0] cnt_q;

  assign tick = (cnt_q == 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else if (restart) begin
      cnt_q <= pre;
    end else if (run) begin
      cnt_q <= tick ? pre : cnt_q - 8'd1;
    end
  end

endmodule

// File: rtl/tc_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt. Optional prescaler enabled by defining TC_PRESCALE_EN.
module tc_timer
  import tc_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);

  tc_state_e   state_q, state_d;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        en_clr;
  logic        tick;
  logic [1:0]  sel;
  logic        ctrl_wr;
  logic        preset_wr;
  logic [31:0] ctrl_word;

  assign sel       = addr[1:0];
  assign ctrl_wr   = we && (sel == ADDR_CTRL);
  assign preset_wr = we && (sel == ADDR_PRESET);

`ifdef TC_PRESCALE_EN
  logic [7:0] pre_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= 8'd0;
    end else if (ctrl_wr) begin
      pre_q <= wdata[CTRL_PRE_HI:CTRL_PRE_LO];
    end
  end

  tc_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (state_q == LOAD),
    .run     ((state_q == CNT) && en_q),
    .pre     (pre_q),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    ctrl_word               = '0;
    ctrl_word[CTRL_EN]      = en_q;
    ctrl_word[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
    ctrl_word[CTRL_IM]      = im_q;
`ifdef TC_PRESCALE_EN
    ctrl_word[CTRL_PRE_HI:CTRL_PRE_LO] = pre_q;
`endif
  end

  always_comb begin
    case (sel)
      ADDR_CTRL:   rdata = ctrl_word;
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      default:     rdata = '0;
    endcase
  end

  // A CTRL write clears pending; an expiry in the same cycle still sets it.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = ctrl_wr ? 1'b0 : pending_q;
    en_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q <= 32'd1) begin
            count_d   = '0;
            pending_d = 1'b1;
            state_d   = INT;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      INT: begin
        if (mode_q == MODE_RELOAD) begin
          pending_d = 1'b0;
          state_d   = en_q ? LOAD : IDLE;
        end else begin
          en_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Bus write to CTRL takes priority over the one-shot hardware EN clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= '0;
    end else begin
      if (ctrl_wr) begin
        en_q   <= wdata[CTRL_EN];
        mode_q <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        im_q   <= wdata[CTRL_IM];
      end else if (en_clr) begin
        en_q <= 1'b0;
      end
      if (preset_wr) begin
        preset_q <= wdata;
      end
    end
  end

  assign irq = pending_q & im_q;

endmodule

// File: tb/tb_tc_timer.sv
// Directed self-checking bench for tc_timer; covers the prescaler case when
// TC_PRESCALE_EN is defined.
module tb_tc_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  tc_timer #(.ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  logic [31:0] v;
  int ar_cnt [12] = '{0, 2, 1, 0, 0, 2, 1, 0, 0, 2, 1, 0};
  int ar_irq [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  int os_cnt [5]  = '{0, 3, 2, 1, 0};

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, v); check("rst_ctrl", v, 32'd0);
    rd(2'd1, v); check("rst_preset", v, 32'd0);
    rd(2'd2, v); check("rst_count", v, 32'd0);
    #10;
    reset = 1'b1;
    step();

    // One-shot, PRESET=3: irq after E5, EN cleared by hardware.
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) begin
      step();
      rd(2'd2, v);
      check($sformatf("os_count_E%0d", k + 1), v, os_cnt[k]);
      check($sformatf("os_irq_E%0d", k + 1), {31'd0, irq}, (k == 4) ? 32'd1 : 32'd0);
    end
    step();
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    rd(2'd0, v); check("os_ctrl_en_clr", v, 32'h8);
    step();
    check("os_irq_hold2", {31'd0, irq}, 32'd1);
    bus_write(2'd0, 32'h8);
    check("os_irq_clear", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=2: one-cycle pulse every 4 cycles.
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'hB);
    for (int k = 0; k < 12; k++) begin
      step();
      rd(2'd2, v);
      check($sformatf("ar_count_E%0d", k + 1), v, ar_cnt[k]);
      check($sformatf("ar_irq_E%0d", k + 1), {31'd0, irq}, ar_irq[k]);
    end
    bus_write(2'd0, 32'h0);
    check("ar_stop_irq", {31'd0, irq}, 32'd0);
    step(); step(); step();

    // Masked expiry: no irq, EN cleared, later IM write keeps irq low.
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mk_irq_E%0d", k + 1), {31'd0, irq}, 32'd0);
    end
    step();
    rd(2'd0, v); check("mk_ctrl_en_clr", v, 32'h0);
    bus_write(2'd0, 32'h8);
    check("mk_irq_after_im", {31'd0, irq}, 32'd0);
    rd(2'd0, v); check("mk_ctrl", v, 32'h8);
    step();
    check("mk_irq_later", {31'd0, irq}, 32'd0);

    // PRESET rewrite mid-count does not disturb the running count.
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'hB);
    for (int k = 0; k < 7; k++) step();
    rd(2'd2, v); check("pw_count5", v, 32'd5);
    bus_write(2'd1, 32'd50);
    rd(2'd2, v); check("pw_count4", v, 32'd4);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("pw_irq_early%0d", k), {31'd0, irq}, 32'd0);
    end
    step();
    check("pw_irq_expiry", {31'd0, irq}, 32'd1);
    rd(2'd2, v); check("pw_count_zero", v, 32'd0);
    step();
    check("pw_irq_pulse_end", {31'd0, irq}, 32'd0);
    step();
    rd(2'd2, v); check("pw_reload50", v, 32'd50);
    rd(2'd1, v); check("pw_preset", v, 32'd50);
    step();
    rd(2'd2, v); check("pw_count49", v, 32'd49);
    bus_write(2'd0, 32'h0);
    bus_write(2'd2, 32'h1234);
    rd(2'd2, v); check("count_wr_ignored", v, 32'd48);
    bus_write(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v); check("reserved_rd", v, 32'd0);

    // PRESET=0 behaves as PRESET=1: irq after E3.
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    step(); step();
    check("p0_irq_E2", {31'd0, irq}, 32'd0);
    step();
    check("p0_irq_E3", {31'd0, irq}, 32'd1);
    bus_write(2'd0, 32'h0);
    check("p0_irq_clear", {31'd0, irq}, 32'd0);

`ifdef TC_PRESCALE_EN
    // PRE=1, PRESET=2, one-shot: irq 6 edges after enable.
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h19);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("ps_irq_E%0d", k + 1), {31'd0, irq}, 32'd0);
    end
    step();
    check("ps_irq_E6", {31'd0, irq}, 32'd1);
    step();
    rd(2'd0, v); check("ps_ctrl", v, 32'h18);
    bus_write(2'd0, 32'h0);
`else
    bus_write(2'd0, 32'hFF0);
    rd(2'd0, v); check("ctrl_pre_ignored", v, 32'h0);
    bus_write(2'd0, 32'h0);
`endif

    // Asynchronous reset mid-count aborts immediately.
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'hB);
    for (int k = 0; k < 62; k++) step();
    rd(2'd2, v); check("mr_count40", v, 32'd40);
    reset = 1'b0;
    #1;
    check("mr_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, v); check("mr_ctrl", v, 32'd0);
    rd(2'd1, v); check("mr_preset", v, 32'd0);
    rd(2'd2, v); check("mr_count", v, 32'd0);
    step(); step();
    #2;
    reset = 1'b1;
    step(); step();
    rd(2'd2, v); check("mr_count_after", v, 32'd0);
    check("mr_irq_after", {31'd0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
